// File: rtl/seg7_time_decoder.sv
// Receive-side monitor for a two-digit active-low 7-segment display: debounces, decodes, range-checks.
// Optional +1/wrap stepping check is enabled by defining SEG7_DEC_STEP_CHECK_EN.
module seg7_time_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_VALUE     = 59,
    parameter int unsigned CW            = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_ones,
    input  logic [6:0] seg_tens,
    output logic [5:0] value,
    output logic [3:0] ones_bcd,
    output logic [3:0] tens_bcd,
    output logic       valid,
    output logic       update,
    output logic       invalid,
    output logic       wrap,
    output logic       step_err
);

    localparam int unsigned SW = 7;
    localparam int unsigned VW = 6;

    typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_LOCKED} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] samp_ones_q, samp_ones_d, samp_tens_q, samp_tens_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] value_q, value_d;
    logic [3:0]    ones_bcd_q, ones_bcd_d, tens_bcd_q, tens_bcd_d;
    logic          valid_q, valid_d, update_q, update_d, invalid_q, invalid_d;
    logic          wrap_d, step_err_d;

    logic [4:0]    ones_dec, tens_dec;
    logic [VW-1:0] cand_value;
    logic          cand_legal, changed, accept;

    // Returns {legal, digit}; anything outside the ten glyphs (blank included) is illegal.
    function automatic logic [4:0] seg_decode(input logic [SW-1:0] seg);
        case (seg)
            7'b0000001: seg_decode = {1'b1, 4'd0};
            7'b1001111: seg_decode = {1'b1, 4'd1};
            7'b0010010: seg_decode = {1'b1, 4'd2};
            7'b0000110: seg_decode = {1'b1, 4'd3};
            7'b1001100: seg_decode = {1'b1, 4'd4};
            7'b0100100: seg_decode = {1'b1, 4'd5};
            7'b0100000: seg_decode = {1'b1, 4'd6};
            7'b0001111: seg_decode = {1'b1, 4'd7};
            7'b0000000: seg_decode = {1'b1, 4'd8};
            7'b0000100: seg_decode = {1'b1, 4'd9};
            default:    seg_decode = {1'b0, 4'd0};
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        samp_ones_d = samp_ones_q;
        samp_tens_d = samp_tens_q;
        cnt_d       = cnt_q;
        value_d     = value_q;
        ones_bcd_d  = ones_bcd_q;
        tens_bcd_d  = tens_bcd_q;
        valid_d     = valid_q;
        invalid_d   = invalid_q;
        update_d    = 1'b0;
        wrap_d      = 1'b0;
        step_err_d  = 1'b0;
        accept      = 1'b0;

        // Decode works on the sampled pair: acceptance only happens when input == sample.
        ones_dec   = seg_decode(samp_ones_q);
        tens_dec   = seg_decode(samp_tens_q);
        cand_value = (VW'(tens_dec[3:0]) << 3) + (VW'(tens_dec[3:0]) << 1) + VW'(ones_dec[3:0]);
        cand_legal = ones_dec[4] && tens_dec[4] && (tens_dec[3:0] <= 4'd5)
                     && (cand_value <= VW'(MAX_VALUE));
        changed    = ({seg_tens, seg_ones} != {samp_tens_q, samp_ones_q});

        if (changed) begin
            samp_ones_d = seg_ones;
            samp_tens_d = seg_tens;
            cnt_d       = '0;
            state_d     = ST_SETTLE;
        end else begin
            if (cnt_q < CW'(STABLE_CYCLES)) begin
                cnt_d = cnt_q + CW'(1);
            end
            accept = (state_q == ST_SETTLE) && (cnt_q == CW'(STABLE_CYCLES - 1));
        end

        if (accept) begin
            state_d = ST_LOCKED;
            if (cand_legal) begin
                value_d    = cand_value;
                ones_bcd_d = ones_dec[3:0];
                tens_bcd_d = tens_dec[3:0];
                valid_d    = 1'b1;
                invalid_d  = 1'b0;
                // A glitch that settles back onto the held reading stays silent.
                if (!valid_q || (cand_value != value_q)) begin
                    update_d = 1'b1;
                    if (valid_q) begin
                        wrap_d     = (value_q == VW'(MAX_VALUE)) && (cand_value == '0);
                        step_err_d = !wrap_d && (cand_value != (value_q + VW'(1)));
                    end
                end
            end else begin
                valid_d   = 1'b0;
                invalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WAIT;
            samp_ones_q <= 7'h7F;
            samp_tens_q <= 7'h7F;
            cnt_q       <= '0;
            value_q     <= '0;
            ones_bcd_q  <= '0;
            tens_bcd_q  <= '0;
            valid_q     <= 1'b0;
            update_q    <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_ones_q <= samp_ones_d;
            samp_tens_q <= samp_tens_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            ones_bcd_q  <= ones_bcd_d;
            tens_bcd_q  <= tens_bcd_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            invalid_q   <= invalid_d;
        end
    end

`ifdef SEG7_DEC_STEP_CHECK_EN
    logic wrap_q, step_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            step_err_q <= step_err_d;
        end
    end

    assign wrap     = wrap_q;
    assign step_err = step_err_q;
`else
    logic unused_step;
    assign unused_step = wrap_d ^ step_err_d;
    assign wrap        = 1'b0;
    assign step_err    = 1'b0;
`endif

    assign value    = value_q;
    assign ones_bcd = ones_bcd_q;
    assign tens_bcd = tens_bcd_q;
    assign valid    = valid_q;
    assign update   = update_q;
    assign invalid  = invalid_q;

endmodule
